// File: rtl/imm_ext_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imm_ext_arbiter
// Brief    : Round-robin share of one immediate extender between decode and
//            branch-target requesters, with a single registered output slot.
//            Define IMM_EXT_ARB_SIGN_EN to honour REQx_SEXT (else zero-extend).
// Revision : 1.0 - initial release
// ============================================================================
module imm_ext_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int IMMDATA_WIDTH = 21
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     REQ0_VALID,
    output logic                     REQ0_READY,
    input  logic [IMMDATA_WIDTH-1:0] REQ0_IMMDATA,
    input  logic                     REQ0_SEXT,
    input  logic                     REQ1_VALID,
    output logic                     REQ1_READY,
    input  logic [IMMDATA_WIDTH-1:0] REQ1_IMMDATA,
    input  logic                     REQ1_SEXT,
    output logic [DATA_WIDTH-1:0]    ODATA,
    output logic                     OVALID,
    input  logic                     OREADY,
    output logic                     OGNT
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [DATA_WIDTH-1:0]    odata;
    logic [DATA_WIDTH-1:0]    odata_nxt;
    logic                     ognt;
    logic                     ognt_nxt;
    logic                     prio;
    logic                     prio_nxt;

    logic                     accept_ok;
    logic                     accept;
    logic                     sel;
    logic                     sext_sel;
    logic [IMMDATA_WIDTH-1:0] imm_sel;
    logic [DATA_WIDTH-1:0]    ext;

    // Both valid -> PRIO decides; otherwise whichever one is valid.
    assign sel       = REQ1_VALID & (~REQ0_VALID | prio);
    assign imm_sel   = sel ? REQ1_IMMDATA : REQ0_IMMDATA;
    assign accept_ok = (state == EMPTY) | OREADY;
    assign accept    = (REQ0_VALID | REQ1_VALID) & accept_ok & RST_N;

    assign REQ0_READY = accept & ~sel;
    assign REQ1_READY = accept & sel;

`ifdef IMM_EXT_ARB_SIGN_EN
    assign sext_sel = sel ? REQ1_SEXT : REQ0_SEXT;
`else
    // Sign-extend inputs are deliberately ignored in this build.
    logic sext_unused;
    assign sext_unused = REQ0_SEXT | REQ1_SEXT;
    assign sext_sel    = 1'b0;
`endif

    generate
        if (DATA_WIDTH == IMMDATA_WIDTH) begin : g_pass
            assign ext = imm_sel;
        end else begin : g_ext
            assign ext = {{(DATA_WIDTH-IMMDATA_WIDTH){sext_sel & imm_sel[IMMDATA_WIDTH-1]}},
                          imm_sel};
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        odata_nxt = odata;
        ognt_nxt  = ognt;
        prio_nxt  = prio;
        case (state)
            EMPTY: if (accept) state_nxt = FULL;
            FULL:  if (OREADY && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
        if (accept) begin
            odata_nxt = ext;
            ognt_nxt  = sel;
            prio_nxt  = ~sel;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= EMPTY;
            odata <= '0;
            ognt  <= 1'b0;
            prio  <= 1'b0;
        end else begin
            state <= state_nxt;
            odata <= odata_nxt;
            ognt  <= ognt_nxt;
            prio  <= prio_nxt;
        end
    end

    assign ODATA  = odata;
    assign OGNT   = ognt;
    assign OVALID = (state == FULL);

endmodule
`default_nettype wire

// File: tb/tb_imm_ext_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_ext_arbiter
// Brief    : Directed self-checking bench for imm_ext_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_ext_arbiter;

    logic        CLK;
    logic        RST_N;
    logic        REQ0_VALID;
    logic        REQ0_READY;
    logic [20:0] REQ0_IMMDATA;
    logic        REQ0_SEXT;
    logic        REQ1_VALID;
    logic        REQ1_READY;
    logic [20:0] REQ1_IMMDATA;
    logic        REQ1_SEXT;
    logic [31:0] ODATA;
    logic        OVALID;
    logic        OREADY;
    logic        OGNT;

    int total = 0;
    int bad   = 0;

    imm_ext_arbiter #(
        .DATA_WIDTH    (32),
        .IMMDATA_WIDTH (21)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .REQ0_VALID   (REQ0_VALID),
        .REQ0_READY   (REQ0_READY),
        .REQ0_IMMDATA (REQ0_IMMDATA),
        .REQ0_SEXT    (REQ0_SEXT),
        .REQ1_VALID   (REQ1_VALID),
        .REQ1_READY   (REQ1_READY),
        .REQ1_IMMDATA (REQ1_IMMDATA),
        .REQ1_SEXT    (REQ1_SEXT),
        .ODATA        (ODATA),
        .OVALID       (OVALID),
        .OREADY       (OREADY),
        .OGNT         (OGNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    logic [31:0] sext_exp;

    initial begin
`ifdef IMM_EXT_ARB_SIGN_EN
        sext_exp = 32'hFFF0_0000;
`else
        sext_exp = 32'h0010_0000;
`endif
        RST_N = 1'b0; OREADY = 1'b0;
        REQ0_VALID = 1'b1; REQ0_IMMDATA = 21'h0; REQ0_SEXT = 1'b0;
        REQ1_VALID = 1'b0; REQ1_IMMDATA = 21'h0; REQ1_SEXT = 1'b0;

        // Reset held: no handshake even with a valid request.
        #2;
        chk("rst_ready0", {31'd0, REQ0_READY}, 32'd0);
        chk("rst_ovalid", {31'd0, OVALID}, 32'd0);
        repeat (3) @(posedge CLK);
        REQ0_VALID = 1'b0;
        #1 RST_N = 1'b1;
        #4;
        chk("idle_ovalid", {31'd0, OVALID}, 32'd0);
        chk("idle_odata",  ODATA, 32'h0);
        chk("idle_ognt",   {31'd0, OGNT}, 32'd0);
        chk("idle_ready0", {31'd0, REQ0_READY}, 32'd0);
        chk("idle_ready1", {31'd0, REQ1_READY}, 32'd0);

        // Single request on port 0.
        step();
        REQ0_VALID = 1'b1; REQ0_IMMDATA = 21'h1ABCD; OREADY = 1'b1;
        #4;
        chk("single_ready0", {31'd0, REQ0_READY}, 32'd1);
        chk("single_ready1", {31'd0, REQ1_READY}, 32'd0);
        step();
        REQ0_VALID = 1'b0;
        chk("single_ovalid", {31'd0, OVALID}, 32'd1);
        chk("single_odata",  ODATA, 32'h0001_ABCD);
        chk("single_ognt",   {31'd0, OGNT}, 32'd0);

        // Single request on port 1 returns PRIO to 0.
        REQ1_VALID = 1'b1; REQ1_IMMDATA = 21'h00ABC;
        #4;
        chk("p1_ready1", {31'd0, REQ1_READY}, 32'd1);
        step();
        REQ1_VALID = 1'b0;
        chk("p1_odata", ODATA, 32'h0000_0ABC);
        chk("p1_ognt",  {31'd0, OGNT}, 32'd1);

        // Contention: grants alternate 0,1,0,1 back-to-back.
        REQ0_VALID = 1'b1; REQ0_IMMDATA = 21'h00001;
        REQ1_VALID = 1'b1; REQ1_IMMDATA = 21'h00002;
        for (int k = 0; k < 4; k++) begin
            #4;
            chk("rr_ready0", {31'd0, REQ0_READY}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_ready1", {31'd0, REQ1_READY}, (k % 2 == 1) ? 32'd1 : 32'd0);
            step();
            chk("rr_ovalid", {31'd0, OVALID}, 32'd1);
            chk("rr_odata",  ODATA, (k % 2 == 0) ? 32'h1 : 32'h2);
            chk("rr_ognt",   {31'd0, OGNT}, (k % 2 == 0) ? 32'd0 : 32'd1);
        end
        REQ0_VALID = 1'b0;

        // Backpressure: output stalled, REQ1 waiting.
        OREADY = 1'b0; REQ1_IMMDATA = 21'h00055;
        for (int k = 0; k < 3; k++) begin
            #4;
            chk("bp_ready1", {31'd0, REQ1_READY}, 32'd0);
            chk("bp_ovalid", {31'd0, OVALID}, 32'd1);
            chk("bp_odata",  ODATA, 32'h2);
            chk("bp_ognt",   {31'd0, OGNT}, 32'd1);
            step();
        end
        OREADY = 1'b1;
        #4;
        chk("bp_release_ready1", {31'd0, REQ1_READY}, 32'd1);
        step();
        REQ1_VALID = 1'b0;
        chk("bp_new_ovalid", {31'd0, OVALID}, 32'd1);
        chk("bp_new_odata",  ODATA, 32'h55);
        chk("bp_new_ognt",   {31'd0, OGNT}, 32'd1);
        step();
        chk("drain_ovalid", {31'd0, OVALID}, 32'd0);

        // Extension: port 1 sign request, port 0 zero request.
        REQ1_VALID = 1'b1; REQ1_IMMDATA = 21'h100000; REQ1_SEXT = 1'b1;
        step();
        REQ1_VALID = 1'b0; REQ1_SEXT = 1'b0;
        chk("sext_odata", ODATA, sext_exp);
        REQ0_VALID = 1'b1; REQ0_IMMDATA = 21'h100000; REQ0_SEXT = 1'b0;
        step();
        REQ0_VALID = 1'b0;
        chk("zext_odata", ODATA, 32'h0010_0000);
        chk("zext_ognt",  {31'd0, OGNT}, 32'd0);

        // Reset mid-operation (FULL, PRIO=1) clears output asynchronously.
        OREADY = 1'b0;
        #2 RST_N = 1'b0;
        #1;
        chk("arst_ovalid", {31'd0, OVALID}, 32'd0);
        chk("arst_odata",  ODATA, 32'h0);
        chk("arst_ognt",   {31'd0, OGNT}, 32'd0);
        #3 RST_N = 1'b1;
        step();
        OREADY = 1'b1;
        REQ0_VALID = 1'b1; REQ0_IMMDATA = 21'h00011;
        REQ1_VALID = 1'b1; REQ1_IMMDATA = 21'h00022;
        #4;
        chk("post_rst_ready0", {31'd0, REQ0_READY}, 32'd1);
        chk("post_rst_ready1", {31'd0, REQ1_READY}, 32'd0);
        step();
        chk("post_rst_odata0", ODATA, 32'h11);
        chk("post_rst_ognt0",  {31'd0, OGNT}, 32'd0);
        step();
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        chk("post_rst_odata1", ODATA, 32'h22);
        chk("post_rst_ognt1",  {31'd0, OGNT}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
